// File: rtl/igen_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : igen_sched_pkg                                                   |
// | Brief   : Shared constants and FSM state type for the category scheduler. |
// |           Category bit positions match the verification-side bitmask.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package igen_sched_pkg;

  // One-hot bit positions of the instruction categories
  localparam int CAT_LOAD  = 0;
  localparam int CAT_STORE = 1;
  localparam int CAT_ARITH = 2;

  // Galois LFSR, x^32+x^22+x^2+x+1, shift-right form
  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_2345;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PICK  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/igen_cat_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : igen_cat_sched_if                                              |
// | Brief     : Valid/ready category offer from scheduler to the instruction  |
// |             builder. master = scheduler, slave = builder.                  |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface igen_cat_sched_if #(
  parameter int NUM_CAT = 3
) ();
  logic               cat_valid;
  logic [NUM_CAT-1:0] cat_onehot;
  logic               cat_ready;

  modport master (output cat_valid, output cat_onehot, input cat_ready);
  modport slave  (input cat_valid, input cat_onehot, output cat_ready);
endinterface
`default_nettype wire

// File: rtl/igen_lfsr32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : igen_lfsr32                                                       |
// | Brief  : 32-bit Galois LFSR, shift right, with seed load. A zero load     |
// |          value is replaced by SEED so the register never locks up.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module igen_lfsr32
  import igen_sched_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] q
);

  // Load takes priority; otherwise step once per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (load) begin
      q <= (load_val == 32'h0) ? SEED : load_val;
    end else if (en) begin
      q <= (q >> 1) ^ (q[0] ? LFSR_POLY : 32'h0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/igen_cat_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : igen_cat_sched                                                    |
// | Brief  : Draws one enabled instruction category per instruction using a   |
// |          seeded LFSR and offers it downstream over valid/ready. Falls     |
// |          back to the lowest enabled category after RETRY_MAX rejects.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module igen_cat_sched
  import igen_sched_pkg::*;
#(
  parameter int          NUM_CAT   = 3,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345,
  parameter int          RETRY_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_CAT-1:0]   typemask,
  input  logic [CNT_W-1:0]     num_instr,
  input  logic                 seed_load,
  input  logic [31:0]          seed,
  igen_cat_sched_if.master     cat,
  output logic                 busy,
  output logic                 done,
  output logic                 err_empty_mask,
  output logic [CNT_W-1:0]     issued_total
);

  localparam int IDX_W   = (NUM_CAT > 1) ? $clog2(NUM_CAT) : 1;
  localparam int RETRY_W = $clog2(RETRY_MAX + 1);

  sched_state_t       state;
  logic [NUM_CAT-1:0] mask;
  logic [CNT_W-1:0]   count;
  logic [RETRY_W-1:0] retry;
  logic [31:0]        lfsr;
  logic [IDX_W-1:0]   idx;
  logic               hit;
  logic [NUM_CAT-1:0] draw_onehot;
  logic [NUM_CAT-1:0] low_onehot;
  logic               low_found;
  logic [CNT_W-1:0]   issued_next;
  logic               unused_lfsr_hi;

  // The LFSR steps on every PICK cycle, accepting or not; seed loads only while idle
  igen_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state == S_PICK),
    .load     (seed_load && (state == S_IDLE)),
    .load_val (seed),
    .q        (lfsr)
  );

  assign idx            = lfsr[IDX_W-1:0];
  assign unused_lfsr_hi = ^lfsr[31:IDX_W];
  assign issued_next    = issued_total + CNT_W'(1);
  assign busy           = (state != S_IDLE);

  // Decode the LFSR draw against the mask; out-of-range indices never hit
  always_comb begin
    hit         = 1'b0;
    draw_onehot = '0;
    for (int i = 0; i < NUM_CAT; i++) begin
      if ((idx == IDX_W'(i)) && mask[i]) begin
        hit            = 1'b1;
        draw_onehot[i] = 1'b1;
      end
    end
  end

  // Lowest enabled category, used when the retry budget is exhausted
  always_comb begin
    low_onehot = '0;
    low_found  = 1'b0;
    for (int i = 0; i < NUM_CAT; i++) begin
      if (mask[i] && !low_found) begin
        low_onehot[i] = 1'b1;
        low_found     = 1'b1;
      end
    end
  end

  // Scheduler FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      mask           <= '0;
      count          <= '0;
      retry          <= '0;
      cat.cat_valid  <= 1'b0;
      cat.cat_onehot <= '0;
      done           <= 1'b0;
      err_empty_mask <= 1'b0;
      issued_total   <= '0;
    end else begin
      done           <= 1'b0;
      err_empty_mask <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (typemask == '0) begin
              err_empty_mask <= 1'b1;
            end else begin
              mask         <= typemask;
              count        <= num_instr;
              issued_total <= '0;
              retry        <= '0;
              if (num_instr == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_PICK;
              end
            end
          end
        end
        S_PICK: begin
          if (retry == RETRY_W'(RETRY_MAX)) begin
            cat.cat_onehot <= low_onehot;
            cat.cat_valid  <= 1'b1;
            state          <= S_ISSUE;
          end else if (hit) begin
            cat.cat_onehot <= draw_onehot;
            cat.cat_valid  <= 1'b1;
            state          <= S_ISSUE;
          end else begin
            retry <= retry + RETRY_W'(1);
          end
        end
        S_ISSUE: begin
          if (cat.cat_valid && cat.cat_ready) begin
            cat.cat_valid  <= 1'b0;
            cat.cat_onehot <= '0;
            issued_total   <= issued_next;
            if (issued_next == count) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_PICK;
              retry <= '0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_igen_cat_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_igen_cat_sched                                                 |
// | Brief  : Table-driven self-checking bench for igen_cat_sched with a       |
// |          reference LFSR/pick model and directed corner sequences.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_igen_cat_sched;

  localparam int          NUM_CAT   = 3;
  localparam int          CNT_W     = 16;
  localparam logic [31:0] SEED      = 32'hACE1_2345;
  localparam int          RETRY_MAX = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       typemask = '0;
  logic [15:0]      num_instr = '0;
  logic             seed_load = 1'b0;
  logic [31:0]      seed = '0;
  logic             busy;
  logic             done;
  logic             err_empty_mask;
  logic [CNT_W-1:0] issued_total;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] ref_lfsr;

  igen_cat_sched_if #(.NUM_CAT(NUM_CAT)) cat_if ();

  igen_cat_sched #(
    .NUM_CAT   (NUM_CAT),
    .CNT_W     (CNT_W),
    .LFSR_SEED (SEED),
    .RETRY_MAX (RETRY_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .typemask       (typemask),
    .num_instr      (num_instr),
    .seed_load      (seed_load),
    .seed           (seed),
    .cat            (cat_if),
    .busy           (busy),
    .done           (done),
    .err_empty_mask (err_empty_mask),
    .issued_total   (issued_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mask;
    logic [15:0] num;
    logic        sl;
    logic [31:0] sd;
    logic        rnd;
    logic        chk_dist;
    int          exp_total;
    int          exp_dones;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: bound expired, got timeout expected event", name);
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic lsb;
    lsb = s[0];
    s   = s >> 1;
    if (lsb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  function automatic logic [2:0] lowest_bit(input logic [2:0] m);
    if (m[0]) return 3'b001;
    if (m[1]) return 3'b010;
    if (m[2]) return 3'b100;
    return 3'b000;
  endfunction

  // Reference pick: one LFSR step per PICK cycle, fallback after RETRY_MAX rejects
  task automatic model_pick(input logic [2:0] m, output logic [2:0] c);
    int retry = 0;
    logic [1:0] idx;
    c = 3'b000;
    while (c == 3'b000 && retry <= RETRY_MAX) begin
      idx = ref_lfsr[1:0];
      if (retry == RETRY_MAX) c = lowest_bit(m);
      else if (idx < 2'd3 && m[idx]) c = 3'b001 << idx;
      ref_lfsr = lfsr_step(ref_lfsr);
      retry++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int hs = 0;
    int dones = 0;
    int done_cyc = -1;
    int last_hs_cyc = -1;
    int cnt[3] = '{0, 0, 0};
    int budget;
    bit finished = 0;
    bit saw_valid = 0;
    logic prev_hs = 0;
    logic prev_stall = 0;
    logic [2:0] prev_cat = '0;
    logic [2:0] exp_cat;
    budget = int'(v.num) * 30 + 50;
    @(negedge clk);
    seed_load = v.sl;
    seed      = v.sd;
    start     = 1'b1;
    typemask  = v.mask;
    num_instr = v.num;
    cat_if.cat_ready = 1'b0;
    if (v.sl) ref_lfsr = (v.sd == 32'h0) ? SEED : v.sd;
    for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      seed_load = 1'b0;
      cat_if.cat_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_hs) check("valid_drop", {31'h0, cat_if.cat_valid}, 32'h0);
      if (prev_stall) check("hold_cat", {29'h0, cat_if.cat_onehot}, {29'h0, prev_cat});
      if (cat_if.cat_valid) saw_valid = 1;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check("busy_after_done", {31'h0, busy}, 32'h0);
        finished = 1;
      end
      prev_hs    = cat_if.cat_valid && cat_if.cat_ready;
      prev_stall = cat_if.cat_valid && !cat_if.cat_ready;
      prev_cat   = cat_if.cat_onehot;
      if (prev_hs) begin
        model_pick(v.mask, exp_cat);
        check("cat_onehot", {29'h0, cat_if.cat_onehot}, {29'h0, exp_cat});
        for (int k = 0; k < 3; k++) if (exp_cat[k]) cnt[k]++;
        hs++;
        last_hs_cyc = cyc;
      end
    end
    if (!finished) fail_now("run_done");
    check("handshakes", hs, v.exp_total);
    check("done_pulses", dones, v.exp_dones);
    check("issued_total", {16'h0, issued_total}, v.exp_total);
    check("saw_valid", {31'h0, saw_valid}, {31'h0, (v.num != 16'h0)});
    if (v.num == 16'h0) check("done_cycle0", done_cyc, 1);
    else check("done_after_last_hs", done_cyc, last_hs_cyc + 1);
    if (v.chk_dist) begin
      for (int k = 0; k < 3; k++)
        check("cat_distribution", {31'h0, (cnt[k] >= 273 && cnt[k] <= 393)}, 32'h1);
    end
  endtask

  initial begin
    logic [2:0] exp_cat;
    int hs;
    bit seen;
    vec_t replay;

    //          mask    num  sl  seed          rnd chk tot dones
    vecs[0] = '{3'b010, 4,   0, 32'h0,         0,  0,  4,  1};
    vecs[1] = '{3'b111, 0,   0, 32'h0,         0,  0,  0,  1};
    vecs[2] = '{3'b111, 999, 1, 32'h0000_0001, 0,  1,  999, 1};
    vecs[3] = '{3'b101, 20,  0, 32'h0,         1,  0,  20, 1};
    vecs[4] = '{3'b100, 3,   0, 32'h0,         0,  0,  3,  1};
    vecs[5] = '{3'b110, 12,  1, 32'h0,         1,  0,  12, 1};
    vecs[6] = '{3'b011, 7,   0, 32'h0,         1,  0,  7,  1};

    cat_if.cat_ready = 1'b0;
    ref_lfsr = SEED;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err_empty_mask}, 32'h0);
    check("rst_valid", {31'h0, cat_if.cat_valid}, 32'h0);
    check("rst_onehot", {29'h0, cat_if.cat_onehot}, 32'h0);
    check("rst_total", {16'h0, issued_total}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Empty mask: error pulse only, total untouched
    @(negedge clk);
    start = 1'b1; typemask = 3'b000; num_instr = 16'd5;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", {31'h0, err_empty_mask}, 32'h1);
    check("err_busy", {31'h0, busy}, 32'h0);
    check("err_valid", {31'h0, cat_if.cat_valid}, 32'h0);
    check("err_total", {16'h0, issued_total}, 32'd7);
    @(negedge clk);
    check("err_one_cycle", {31'h0, err_empty_mask}, 32'h0);
    check("err_busy2", {31'h0, busy}, 32'h0);

    // Backpressure: hold ready low for 5 offered cycles
    cat_if.cat_ready = 1'b0;
    start = 1'b1; typemask = 3'b001; num_instr = 16'd1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (cat_if.cat_valid) seen = 1;
    end
    if (!seen) fail_now("bp_wait_valid");
    model_pick(3'b001, exp_cat);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_cat", {29'h0, cat_if.cat_onehot}, {29'h0, exp_cat});
      check("bp_valid", {31'h0, cat_if.cat_valid}, 32'h1);
      check("bp_total", {16'h0, issued_total}, 32'h0);
    end
    @(negedge clk);
    cat_if.cat_ready = 1'b1;
    check("bp_total_pre", {16'h0, issued_total}, 32'h0);
    @(negedge clk);
    cat_if.cat_ready = 1'b0;
    check("bp_total_post", {16'h0, issued_total}, 32'h1);
    check("bp_done", {31'h0, done}, 32'h1);
    check("bp_valid_drop", {31'h0, cat_if.cat_valid}, 32'h0);
    @(negedge clk);
    check("bp_idle", {31'h0, busy}, 32'h0);

    // Reset during ISSUE after a few handshakes, then replay from the reset seed
    @(negedge clk);
    start = 1'b1; typemask = 3'b111; num_instr = 16'd10;
    cat_if.cat_ready = 1'b1;
    hs = 0;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (hs >= 3 && cat_if.cat_valid) seen = 1;
      else if (cat_if.cat_valid && cat_if.cat_ready) hs++;
    end
    if (!seen) fail_now("rst_wait_issue");
    check("pre_rst_total", {16'h0, issued_total}, 32'd3);
    cat_if.cat_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, cat_if.cat_valid}, 32'h0);
    check("mid_rst_onehot", {29'h0, cat_if.cat_onehot}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    check("mid_rst_err", {31'h0, err_empty_mask}, 32'h0);
    check("mid_rst_total", {16'h0, issued_total}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_lfsr = SEED;
    replay = '{3'b111, 10, 0, 32'h0, 0, 0, 10, 1};
    run_vec(replay);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/igen_cat_sched.md
# igen_cat_sched

Hardware instruction-category scheduler for the RISC-V stimulus generator. It latches a category bitmask and an instruction count, then draws one enabled category per instruction with a seeded 32-bit LFSR. Each draw is issued to the downstream instruction builder over a valid/ready handshake, and the block pulses `done` after the last handshake. It is the synthesizable counterpart of the random "pick a set bit from the mask" selection and sits between the test-sequence configuration registers and the load/store/arithmetic instruction encoders.

## Interface
Parameters:
- `NUM_CAT`, 3, number of categories; one-hot bit order LOAD=bit0, STORE=bit1, ARITHMETIC=bit2.
- `CNT_W`, 16, width of the instruction count and the issued counter.
- `LFSR_SEED`, 32'hACE1_2345, reset value of the LFSR; also substituted whenever a zero seed is loaded.
- `RETRY_MAX`, 8, number of rejected draws before the fallback pick.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `typemask` in NUM_CAT: enabled categories; latched on an accepted `start`.
- `num_instr` in CNT_W: number of instructions to issue; latched on an accepted `start`.
- `seed_load` in 1: load `seed` into the LFSR; honoured only in IDLE.
- `seed` in 32: new LFSR value.
- `cat_valid` out 1: a category is offered downstream.
- `cat_onehot` out NUM_CAT: the offered category, one-hot.
- `cat_ready` in 1: downstream accepts the offered category.
- `busy` out 1: high in every state other than IDLE.
- `done` out 1: one-cycle pulse after the final handshake.
- `err_empty_mask` out 1: one-cycle pulse when `start` arrives with `typemask`==0.
- `issued_total` out CNT_W: handshakes completed in the current or most recent run.

## Operation
- FSM states: IDLE, PICK, ISSUE, DONE.
- IDLE:
  - `start` with a nonzero mask: latch mask and count, clear `issued_total`, go to PICK. If `num_instr`==0, go to DONE instead.
  - `start` with a zero mask: pulse `err_empty_mask`, stay in IDLE, leave `issued_total` unchanged.
  - `seed_load` and `start` in the same cycle: the seed is loaded first, and the run uses the new seed.
- PICK:
  - `idx` = `lfsr[$clog2(NUM_CAT)-1:0]`.
  - Accept when `idx` < NUM_CAT and `mask[idx]` is set. Register `cat_onehot`=1<<idx, go to ISSUE.
  - Otherwise advance the LFSR, increment the retry counter and stay in PICK.
  - When the retry counter reaches RETRY_MAX, pick the lowest set mask bit instead and go to ISSUE.
  - The retry counter clears on every entry to PICK.
- The LFSR advances exactly once per PICK cycle, including accepting cycles. It does not advance in any other state.
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1, tap mask 32'h8020_0003, shift right. Loading 0 stores LFSR_SEED instead.
- ISSUE:
  - `cat_valid`=1; `cat_onehot` holds stable until the handshake.
  - On `cat_valid`&&`cat_ready`: `issued_total` increments. If the new value equals the latched count, go to DONE; otherwise go to PICK.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `issued_total` holds its value after the run and clears on the next accepted `start`.

## Timing
- Reset values: `cat_valid`=0, `cat_onehot`=0, `busy`=0, `done`=0, `err_empty_mask`=0, `issued_total`=0, LFSR=LFSR_SEED, state IDLE.
- Reset asserted mid-run returns the block to IDLE immediately. Any offered category is dropped with no `done`.
- Latency: `start` in cycle 0 gives PICK in cycle 1 and, with no rejects, `cat_valid` in cycle 2.
- Each reject adds 1 cycle; the worst case is RETRY_MAX+1 PICK cycles.
- Peak throughput is one handshake every 2 cycles.
- A handshake in cycle t:
  - final instruction: `done` in cycle t+1, `busy`=0 in cycle t+2;
  - otherwise: `cat_valid` drops in t+1 and reasserts no earlier than t+2.
- `num_instr`==0: `done` in cycle 1, with no `cat_valid` at any point.
- `err_empty_mask` is asserted in the cycle after the `start`.
- `cat_ready` may be high before `cat_valid`; no combinational path exists from `cat_ready` to `cat_valid`.

## Structure
- Shared package `igen_sched_pkg` holds:
  - the category bit-index constants (LOAD=0, STORE=1, ARITHMETIC=2), matching the verification-side category bitmask encoding;
  - the FSM state enum;
  - LFSR_POLY=32'h8020_0003 and the default seed.
- One sub-module, `igen_lfsr32`, with ports `clk`, `rst_n`, `en`, `load`, `load_val`, `q`, and a seed parameter.
- Scheduler FSM, retry counter and issue counter stay in `igen_cat_sched`.

## Test plan
- Mask 3'b010, `num_instr`=4, `cat_ready` tied high → four handshakes, all with `cat_onehot`=3'b010; `done` pulses once; `issued_total`=4.
- Mask 3'b000 plus `start` → `err_empty_mask` pulses one cycle later; `busy` and `cat_valid` stay 0; `issued_total` is unchanged.
- `num_instr`=0, mask 3'b111 → `done` in cycle 1; `cat_valid` is never asserted.
- Backpressure: hold `cat_ready`=0 for 5 cycles while `cat_valid`=1 → `cat_onehot` is stable all 5 cycles; `issued_total` increments only on the cycle `cat_ready` rises.
- Seed 32'h1, mask 3'b111, `num_instr`=999 → `cat_onehot` is always one-hot within the mask; each category count falls in 333±60; matches the reference-model LFSR sequence exactly.
- Assert reset during ISSUE of a 10-instruction run → all outputs return to their reset values in that cycle; a new `start` runs normally and replays the sequence from LFSR_SEED.
